// File: rtl/riscv_pkg.sv
// RV32I shared definitions: funct3 width codes, LSU state and
// access legality helpers used by decode, ALU control and the LSU.
package riscv_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FIN
  } lsu_state_t;

  // Unsigned widths only exist for loads.
  function automatic logic f3_legal(
    input logic       st,
    input logic [2:0] f3
  );
    logic ok;
    ok = 1'b0;
    unique case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !st;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic f3_misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b0;
    unique case (f3[1:0])
      2'b01:   bad = off[0];
      2'b10:   bad = |off;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide data-memory port with a req/ack handshake.
// The LSU is the master; the memory model or fabric is the slave.
interface load_store_unit_if;
  import riscv_pkg::*;

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    output wstrb,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    input  wstrb,
    output rdata,
    output ack
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for stores and lane
// extraction with sign/zero extension for loads.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] load_word,
  output logic [DATA_W-1:0] store_lanes,
  output logic [3:0]        store_strb,
  output logic [DATA_W-1:0] load_value
);

  logic [15:0] lh;
  logic [7:0]  lb;

  assign lh = offset[1] ? load_word[31:16] : load_word[15:0];
  assign lb = offset[0] ? lh[15:8] : lh[7:0];

  always_comb begin
    store_lanes = store_data;
    store_strb  = 4'b1111;
    unique case (1'b1)
      funct3[1:0] == 2'b00: begin
        store_lanes = {4{store_data[7:0]}};
        store_strb  = 4'b0001 << offset;
      end
      funct3[1:0] == 2'b01: begin
        store_lanes = {2{store_data[15:0]}};
        store_strb  = 4'b0011 << offset;
      end
      default: ;
    endcase
  end

  always_comb begin
    load_value = '0;
    unique case (funct3)
      F3_B:    load_value = {{24{lb[7]}}, lb};
      F3_H:    load_value = {{16{lh[15]}}, lh};
      F3_W:    load_value = load_word;
      F3_BU:   load_value = {24'b0, lb};
      F3_HU:   load_value = {16'b0, lh};
      default: load_value = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: one load/store at a time over a req/ack
// word port, with misalign, illegal-funct3 and ack-timeout faults.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] load_result,
  output logic            misaligned,
  output logic            illegal,
  output logic            bus_error,
  load_store_unit_if.master mem
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  lsu_state_t state, state_next;

  logic [CW-1:0]   cnt;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            store_q;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [3:0]      req_wstrb;

  logic            ill_c;
  logic            mis_c;
  logic            accept;
  logic            fault;
  logic            ack_hit;
  logic            timeout;

  logic [2:0]      al_f3;
  logic [1:0]      al_off;
  logic [XLEN-1:0] st_lanes;
  logic [3:0]      st_strb;
  logic [XLEN-1:0] ld_value;

  assign ill_c = !f3_legal(is_store, funct3);
  assign mis_c = !ill_c && f3_misaligned(funct3, addr[1:0]);

  // IDLE steers the incoming store; REQ extracts with the held code.
  assign al_f3  = (state == IDLE) ? funct3 : f3_q;
  assign al_off = (state == IDLE) ? addr[1:0] : off_q;

  lsu_align u_align (
    .funct3      (al_f3),
    .offset      (al_off),
    .store_data  (store_data),
    .load_word   (mem.rdata),
    .store_lanes (st_lanes),
    .store_strb  (st_strb),
    .load_value  (ld_value)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    fault      = 1'b0;
    ack_hit    = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (ill_c || mis_c) begin
            fault      = 1'b1;
            state_next = FIN;
          end else begin
            accept     = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        if (mem.ack) begin
          ack_hit    = 1'b1;
          state_next = FIN;
        end else if (cnt == LAST) begin
          timeout    = 1'b1;
          state_next = FIN;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      store_q   <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt       <= '0;
        f3_q      <= funct3;
        off_q     <= addr[1:0];
        store_q   <= is_store;
        req_we    <= is_store;
        req_addr  <= {addr[XLEN-1:2], 2'b00};
        req_wdata <= is_store ? st_lanes : '0;
        req_wstrb <= is_store ? st_strb : '0;
      end else if (state == REQ) begin
        if (cnt != '1) begin
          cnt <= cnt + 1'b1;
        end
        if (state_next != REQ) begin
          req_we    <= 1'b0;
          req_addr  <= '0;
          req_wdata <= '0;
          req_wstrb <= '0;
        end
      end
    end
  end

  // Flags live only for the FIN cycle; load_result persists.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_result <= '0;
      illegal     <= 1'b0;
      misaligned  <= 1'b0;
      bus_error   <= 1'b0;
    end else if (fault) begin
      illegal     <= ill_c;
      misaligned  <= mis_c;
      bus_error   <= 1'b0;
      load_result <= '0;
    end else if (timeout) begin
      bus_error   <= 1'b1;
      load_result <= '0;
    end else if (ack_hit) begin
      if (!store_q) begin
        load_result <= ld_value;
      end
    end else if (state == FIN) begin
      illegal    <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign mem.req   = (state == REQ);
  assign mem.we    = req_we;
  assign mem.addr  = req_addr;
  assign mem.wdata = req_wdata;
  assign mem.wstrb = req_wstrb;

endmodule

// File: tb/tb_load_store_unit.sv
// Random and directed RV32I accesses checked against an arithmetic
// reference model through a scoreboard queue and a bus monitor.
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_result;
  logic        misaligned;
  logic        illegal;
  logic        bus_error;

  load_store_unit_if mem_bus ();

  load_store_unit #(
    .XLEN    (32),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_store    (is_store),
    .funct3      (funct3),
    .addr        (addr),
    .store_data  (store_data),
    .busy        (busy),
    .done        (done),
    .load_result (load_result),
    .misaligned  (misaligned),
    .illegal     (illegal),
    .bus_error   (bus_error),
    .mem         (mem_bus.master)
  );

  typedef struct {
    bit        st;
    bit [31:0] rd;
    int        dly;
    int        start_cyc;
    int        lat;
    int        req_cycles;
    bit        ill;
    bit        mis;
    bit        berr;
    bit        we;
    bit [31:0] maddr;
    bit [31:0] wdata;
    bit [3:0]  wstrb;
    bit        chk_lr;
    bit [31:0] lr;
  } exp_t;

  exp_t      q[$];
  exp_t      mon_e;
  exp_t      rst_e;
  int        n_checks;
  int        n_pass;
  int        cyc;
  int        req_cnt;
  bit        prev_req;
  int        n_txn;
  int        n_done;
  int        exp_txn;
  int        exp_done;
  bit [31:0] model_lr;
  bit        lr_known;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
  endtask

  // Expected outcome from the RV32I rules, in bytes and integers.
  function automatic exp_t model(input bit st, input bit [2:0] f3,
                                 input bit [31:0] a, input bit [31:0] sd,
                                 input bit [31:0] rd, input int dly,
                                 input bit [31:0] prev);
    exp_t      e;
    int        nb;
    int        off;
    bit [31:0] m;
    bit [31:0] v;
    e.st = st; e.rd = rd; e.dly = dly; e.start_cyc = 0;
    if (st) e.ill = !(f3 inside {3'd0, 3'd1, 3'd2});
    else e.ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    e.mis = !e.ill && (off % nb != 0);
    e.berr = 0; e.we = 0; e.maddr = 0; e.wdata = 0; e.wstrb = 0;
    e.chk_lr = 0; e.lr = prev;
    if (e.ill || e.mis) begin
      e.lat = 1; e.req_cycles = 0; e.lr = 0;
    end else begin
      e.berr = (dly >= TO);
      e.lat = e.berr ? TO + 1 : dly + 2;
      e.req_cycles = e.berr ? TO : dly + 1;
      e.maddr = {a[31:2], 2'b00};
      e.we = st;
      if (st) begin
        for (int i = 0; i < 4; i++) begin
          e.wdata[8*i +: 8] = sd[8*(i % nb) +: 8];
          e.wstrb[i] = (i >= off) && (i < off + nb);
        end
      end
      if (e.berr) e.lr = 0;
      else if (!st) begin
        m = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
        v = (rd >> (8 * off)) & m;
        if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~m;
        e.lr = v;
      end
    end
    return e;
  endfunction

  // Scoreboard check at done; memory responder and bus monitor.
  always @(negedge clk) begin
    if (rst) begin
      mem_bus.ack   = 1'b0;
      mem_bus.rdata = '0;
      req_cnt       = 0;
      prev_req      = 1'b0;
    end else begin
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_e = q.pop_front();
          chk("latency", 32'(cyc - mon_e.start_cyc), 32'(mon_e.lat));
          chk("illegal", 32'(illegal), 32'(mon_e.ill));
          chk("misaligned", 32'(misaligned), 32'(mon_e.mis));
          chk("bus_error", 32'(bus_error), 32'(mon_e.berr));
          chk("req_cycles", 32'(req_cnt), 32'(mon_e.req_cycles));
          if (mon_e.chk_lr) chk("load_result", load_result, mon_e.lr);
          n_done++;
        end
        req_cnt = 0;
      end
      mem_bus.ack   = 1'b0;
      mem_bus.rdata = $urandom;
      if (mem_bus.req) begin
        if (!prev_req) n_txn++;
        chk("busy_in_req", 32'(busy), 32'd1);
        if (q.size() == 0) begin
          chk("unexpected_req", 32'(mem_bus.req), 32'd0);
        end else begin
          chk("mem_addr", mem_bus.addr, q[0].maddr);
          chk("mem_we", 32'(mem_bus.we), 32'(q[0].we));
          chk("mem_wdata", mem_bus.wdata, q[0].wdata);
          chk("mem_wstrb", 32'(mem_bus.wstrb), 32'(q[0].wstrb));
          if (req_cnt == q[0].dly) begin
            mem_bus.ack   = 1'b1;
            mem_bus.rdata = q[0].rd;
          end
        end
        req_cnt++;
      end else begin
        chk("idle_bus", mem_bus.addr | mem_bus.wdata |
            {27'b0, mem_bus.we, mem_bus.wstrb}, 32'd0);
        if (prev_req || $urandom_range(3) == 0) mem_bus.ack = 1'b1;
      end
      prev_req = mem_bus.req;
    end
  end

  task automatic do_access(input bit st, input bit [2:0] f3,
                           input bit [31:0] a, input bit [31:0] sd,
                           input bit [31:0] rd, input int dly,
                           input bit force_lr = 1'b0,
                           input bit [31:0] lr = 32'd0);
    exp_t e;
    int   guard;
    e = model(st, f3, a, sd, rd, dly, model_lr);
    if (force_lr) begin
      e.lr = lr;
      e.chk_lr = 1'b1;
    end else begin
      e.chk_lr = !st || (lr_known && !e.ill && !e.mis && !e.berr);
    end
    if (!st) begin
      model_lr = e.lr;
      lr_known = 1'b1;
    end else if (e.ill || e.mis || e.berr) begin
      lr_known = 1'b0;
    end
    @(posedge clk); #1;
    is_store = st; funct3 = f3; addr = a; store_data = sd;
    start = 1'b1;
    e.start_cyc = cyc;
    q.push_back(e);
    exp_done++;
    if (!(e.ill || e.mis)) exp_txn++;
    guard = 0;
    do begin
      @(posedge clk); #1;
      start = busy ? 1'($urandom_range(1)) : 1'b0;
      if (start) begin
        is_store   = 1'($urandom);
        funct3     = 3'($urandom);
        addr       = $urandom;
        store_data = $urandom;
      end
      guard++;
    end while ((q.size() != 0 || busy) && guard < 200);
    start = 1'b0;
    if (guard >= 200) begin
      chk("access_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = '0;
    addr = '0; store_data = '0;
    model_lr = '0; lr_known = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_load_result", load_result, 32'd0);
    chk("rst_flags", {29'b0, illegal, misaligned, bus_error}, 32'd0);
    chk("rst_req", 32'(mem_bus.req), 32'd0);

    do_access(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'd0, 3);
    do_access(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'd0, 0);
    do_access(1'b0, 3'b000, 32'h102, 32'd0, 32'h1280_FF34, 1,
              1'b1, 32'hFFFF_FF80);
    do_access(1'b0, 3'b100, 32'h102, 32'd0, 32'h1280_FF34, 2,
              1'b1, 32'h0000_0080);
    do_access(1'b0, 3'b101, 32'h102, 32'd0, 32'h1280_FF34, 0,
              1'b1, 32'h0000_1280);
    do_access(1'b1, 3'b010, 32'h204, 32'h0BAD_F00D, 32'd0, 2,
              1'b1, 32'h0000_1280);
    do_access(1'b0, 3'b010, 32'h101, 32'd0, 32'h1111_1111, 0,
              1'b1, 32'd0);
    do_access(1'b0, 3'b011, 32'h100, 32'd0, 32'h2222_2222, 0,
              1'b1, 32'd0);
    do_access(1'b0, 3'b010, 32'h300, 32'd0, 32'h5555_5555, 1000,
              1'b1, 32'd0);
    do_access(1'b0, 3'b001, 32'h102, 32'd0, 32'h8000_1234, TO - 1,
              1'b1, 32'hFFFF_8000);

    rst_e = model(1'b0, 3'b010, 32'h400, 32'd0, 32'd0, 1000, model_lr);
    @(posedge clk); #1;
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h400; start = 1'b1;
    rst_e.start_cyc = cyc;
    q.push_back(rst_e);
    exp_txn++;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    q.delete();
    model_lr = '0; lr_known = 1'b1;
    @(negedge clk);
    chk("rst_mid_req", 32'(mem_bus.req), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_lr", load_result, 32'd0);
    repeat (3) @(negedge clk);
    do_access(1'b0, 3'b010, 32'h200, 32'd0, 32'h1357_2468, 1,
              1'b1, 32'h1357_2468);

    for (int n = 0; n < 150; n++) begin
      int r;
      int d;
      r = int'($urandom_range(19));
      if (r < 14) d = int'($urandom_range(4));
      else if (r < 16) d = TO - 1;
      else if (r < 18) d = TO;
      else d = 0;
      do_access(1'($urandom), 3'($urandom), $urandom, $urandom,
                $urandom, d);
    end

    repeat (4) @(negedge clk);
    chk("mem_transactions", 32'(n_txn), 32'(exp_txn));
    chk("done_pulses", 32'(n_done), 32'(exp_done));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
